// File: rtl/led_pwm_driver.sv
// Global-brightness PWM with per-channel blink applied to the LED PIO pattern.
// Control inputs are shadowed at PWM period boundaries so mid-period writes never glitch the pins.
module led_pwm_driver #(
    parameter int NUM_LEDS      = 8,
    parameter int PRESCALE      = 195,
    parameter int PWM_BITS      = 8,
    parameter int BLINK_PERIODS = 256
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [NUM_LEDS-1:0] led_in,
    input  logic [PWM_BITS-1:0] duty,
    input  logic [NUM_LEDS-1:0] blink_mask,
    output logic [NUM_LEDS-1:0] led_out,
    output logic                period_start,
    output logic                blink_phase
);

    // Counters are kept at least 1 bit wide so PRESCALE=1 / BLINK_PERIODS=1 still elaborate.
    localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int BL_W  = (BLINK_PERIODS > 1) ? $clog2(BLINK_PERIODS) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);
    localparam logic [BL_W-1:0]  BL_LAST  = BL_W'(BLINK_PERIODS - 1);

    logic [PRE_W-1:0]    pre_cnt;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic [BL_W-1:0]     bl_cnt;
    logic [NUM_LEDS-1:0] led_sh;
    logic [NUM_LEDS-1:0] mask_sh;
    logic [PWM_BITS-1:0] duty_sh;
    logic                tick;
    logic                wrap;
    logic                pwm_on;

    assign tick   = (pre_cnt == PRE_LAST);
    assign wrap   = tick && (&pwm_cnt);
    assign pwm_on = (pwm_cnt < duty_sh);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pre_cnt <= '0;
            pwm_cnt <= '0;
        end else begin
            pre_cnt <= tick ? '0 : pre_cnt + PRE_W'(1);
            if (tick) begin
                pwm_cnt <= pwm_cnt + PWM_BITS'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            led_sh       <= '0;
            duty_sh      <= '0;
            mask_sh      <= '0;
            period_start <= 1'b0;
        end else begin
            period_start <= wrap;
            if (wrap) begin
                led_sh  <= led_in;
                duty_sh <= duty;
                mask_sh <= blink_mask;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bl_cnt      <= '0;
            blink_phase <= 1'b0;
        end else if (wrap) begin
            if (bl_cnt == BL_LAST) begin
                bl_cnt      <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                bl_cnt <= bl_cnt + BL_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            led_out <= '0;
        end else begin
            led_out <= led_sh & {NUM_LEDS{pwm_on}} & ~(mask_sh & {NUM_LEDS{blink_phase}});
        end
    end

endmodule

// File: tb/tb_led_pwm_driver.sv
// Scoreboard bench for led_pwm_driver with PRESCALE=2, PWM_BITS=4, BLINK_PERIODS=2 (32-clk periods).
module tb_led_pwm_driver;

    localparam int PRESCALE = 2;
    localparam int PERIOD   = 32;

    logic       clk;
    logic       reset_n;
    logic [7:0] led_in;
    logic [3:0] duty;
    logic [7:0] blink_mask;
    logic [7:0] led_out;
    logic       period_start;
    logic       blink_phase;

    typedef struct {
        logic [7:0] led;
        logic       ps;
        logic       bp;
    } exp_t;

    exp_t exp_q[$];

    int n_tests = 0;
    int n_fail  = 0;

    // Spec-level model: what the shadows hold and how many boundaries have passed since reset.
    logic [7:0] exp_led_sh;
    logic [3:0] exp_duty_sh;
    logic [7:0] exp_mask_sh;
    int         n_wraps;

    led_pwm_driver #(
        .NUM_LEDS(8),
        .PRESCALE(PRESCALE),
        .PWM_BITS(4),
        .BLINK_PERIODS(2)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .led_in(led_in),
        .duty(duty),
        .blink_mask(blink_mask),
        .led_out(led_out),
        .period_start(period_start),
        .blink_phase(blink_phase)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic phase_of(input int w);
        return ((w / 2) % 2) == 1;
    endfunction

    function automatic void model_reset();
        exp_led_sh  = '0;
        exp_duty_sh = '0;
        exp_mask_sh = '0;
        n_wraps     = 0;
    endfunction

    // Called at the negedge where the current period begins; checks up to last_j following
    // cycles and drives the next period's inputs at cycle change_at.
    task automatic run_period(input logic [7:0] nled, input logic [3:0] nduty,
                              input logic [7:0] nmask, input int change_at,
                              input int last_j, input string name);
        exp_t e;
        logic ph;
        ph = phase_of(n_wraps);
        for (int j = 1; j <= last_j; j++) begin
            e.led = ((j - 1) < PRESCALE * int'(exp_duty_sh))
                    ? (exp_led_sh & ~(exp_mask_sh & {8{ph}})) : 8'h00;
            e.ps  = (j == PERIOD);
            e.bp  = (j == PERIOD) ? phase_of(n_wraps + 1) : ph;
            exp_q.push_back(e);
        end
        for (int j = 1; j <= last_j; j++) begin
            @(negedge clk);
            if (j == change_at) begin
                led_in     = nled;
                duty       = nduty;
                blink_mask = nmask;
            end
            e = exp_q.pop_front();
            n_tests++;
            if (led_out !== e.led) begin
                n_fail++;
                $display("FAIL %s led_out clk %0d: got %h expected %h", name, j, led_out, e.led);
            end
            n_tests++;
            if (period_start !== e.ps) begin
                n_fail++;
                $display("FAIL %s period_start clk %0d: got %b expected %b", name, j, period_start, e.ps);
            end
            n_tests++;
            if (blink_phase !== e.bp) begin
                n_fail++;
                $display("FAIL %s blink_phase clk %0d: got %b expected %b", name, j, blink_phase, e.bp);
            end
        end
        if (last_j == PERIOD) begin
            exp_led_sh  = led_in;
            exp_duty_sh = duty;
            exp_mask_sh = blink_mask;
            n_wraps++;
        end
    endtask

    task automatic test_reset();
        reset_n    = 1'b0;
        led_in     = 8'hFF;
        duty       = 4'd8;
        blink_mask = 8'h00;
        model_reset();
        repeat (3) @(negedge clk);
        n_tests++;
        if (led_out !== 8'h00) begin
            n_fail++;
            $display("FAIL reset led_out: got %h expected 00", led_out);
        end
        n_tests++;
        if (period_start !== 1'b0) begin
            n_fail++;
            $display("FAIL reset period_start: got %b expected 0", period_start);
        end
        n_tests++;
        if (blink_phase !== 1'b0) begin
            n_fail++;
            $display("FAIL reset blink_phase: got %b expected 0", blink_phase);
        end
        reset_n = 1'b1;
        run_period(8'hFF, 4'd8, 8'h00, 1, PERIOD, "startup");
    endtask

    task automatic test_basic();
        run_period(8'hFF, 4'd8, 8'h00, 1, PERIOD, "basic_p1");
        run_period(8'hFF, 4'd0, 8'h00, 1, PERIOD, "basic_p2");
    endtask

    task automatic test_duty_extremes();
        run_period(8'hFF, 4'd15, 8'h00, 1, PERIOD, "duty8");
        run_period(8'h0F, 4'd15, 8'h00, 1, PERIOD, "duty0");
        run_period(8'h0F, 4'd15, 8'h00, 1, PERIOD, "duty15");
    endtask

    task automatic test_midperiod_change();
        run_period(8'hF0, 4'd15, 8'h00, 10, PERIOD, "midchange_old");
        run_period(8'h03, 4'd15, 8'h01, 1, PERIOD, "midchange_new");
    endtask

    task automatic test_blink();
        run_period(8'h03, 4'd15, 8'h01, 1, PERIOD, "blink_a");
        run_period(8'h03, 4'd15, 8'h01, 1, PERIOD, "blink_b");
        run_period(8'h03, 4'd15, 8'h01, 1, PERIOD, "blink_c");
        run_period(8'hFF, 4'd15, 8'h00, 1, PERIOD, "blink_d");
    endtask

    task automatic test_reset_midperiod();
        run_period(8'hFF, 4'd15, 8'h00, 1, PERIOD, "pre_rst_a");
        run_period(8'hFF, 4'd15, 8'h00, 1, PERIOD, "pre_rst_b");
        run_period(8'hFF, 4'd15, 8'h00, 1, 5, "pre_rst_c");
        #2 reset_n = 1'b0;
        #1;
        n_tests++;
        if (led_out !== 8'h00) begin
            n_fail++;
            $display("FAIL async_reset led_out: got %h expected 00", led_out);
        end
        n_tests++;
        if (blink_phase !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset blink_phase: got %b expected 0", blink_phase);
        end
        n_tests++;
        if (period_start !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset period_start: got %b expected 0", period_start);
        end
        repeat (2) @(negedge clk);
        model_reset();
        reset_n = 1'b1;
        run_period(8'hFF, 4'd4, 8'h00, 1, PERIOD, "restart");
    endtask

    task automatic test_back_to_back();
        run_period(8'hFF, 4'd12, 8'h00, 31, PERIOD, "duty4_edge");
        run_period(8'hFF, 4'd12, 8'h00, 1, PERIOD, "duty12");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_duty_extremes();
        test_midperiod_change();
        test_blink();
        test_reset_midperiod();
        test_back_to_back();
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d entries left expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/led_pwm_driver.md
Name: led_pwm_driver

Overview:
Downstream consumer of the 8-bit LED PIO output register. Applies a global PWM brightness and per-LED blink to the PIO's LED on/off pattern, then drives the board LED pins. Control inputs are captured only at PWM period boundaries, so CPU writes never produce glitches or partial periods. All inputs are in the clk domain, driven by PIO registers; no synchronisers are required.

Parameters:
NUM_LEDS, 8, number of LED channels
PRESCALE, 195, clk cycles per PWM count step; must be >= 1
PWM_BITS, 8, PWM counter width; one period = PRESCALE * 2^PWM_BITS clk cycles
BLINK_PERIODS, 256, PWM periods per blink half-phase; must be >= 1

Ports:
clk  in  1  system clock
reset_n  in  1  reset
led_in  in  NUM_LEDS  LED on/off pattern from the LED PIO out_port
duty  in  PWM_BITS  global brightness; on-time = duty / 2^PWM_BITS
blink_mask  in  NUM_LEDS  1 = channel blinks at blink_phase rate
led_out  out  NUM_LEDS  LED pin drive, registered, active-high
period_start  out  1  one-clk pulse in the first cycle of each PWM period
blink_phase  out  1  current blink phase; 1 = blinking channels forced off

Behaviour:
- Reset: reset_n is asynchronous, active-low; clock is clk. During reset, every counter, every shadow register, led_out, period_start and blink_phase is 0.
- Prescaler:
  - pre_cnt counts 0..PRESCALE-1 and wraps to 0.
  - tick = (pre_cnt == PRESCALE-1), combinational.
  - With PRESCALE=1, tick is permanently 1.
- PWM counter:
  - pwm_cnt advances by 1 on each tick and wraps from 2^PWM_BITS-1 to 0.
  - wrap = tick && pwm_cnt == 2^PWM_BITS-1.
- Period boundary, on the clk edge where wrap is true:
  - led_sh <= led_in, duty_sh <= duty, mask_sh <= blink_mask.
  - period_start <= 1. Otherwise period_start <= 0.
- Shadow registers change only at a boundary. Input changes mid-period are ignored until the next boundary; only the value present on the boundary edge is captured.
- Blink counter:
  - bl_cnt counts wraps 0..BLINK_PERIODS-1.
  - On the wrap that takes bl_cnt from BLINK_PERIODS-1 to 0, blink_phase toggles.
  - Blink cadence: blink_phase holds for BLINK_PERIODS periods per half-phase.
- Compare: pwm_on = (pwm_cnt < duty_sh), unsigned compare.
  - duty_sh = 0 gives LED fully off.
  - duty_sh = 2^PWM_BITS-1 gives max on-time of (2^PWM_BITS-1)/2^PWM_BITS. There is no 100% state.
- Output, registered every clk:
  - led_out[i] <= led_sh[i] & pwm_on & ~(mask_sh[i] & blink_phase).
  - Latency: led_out reflects counter/shadow state with 1 clk delay.
  - After a boundary edge, new shadow values first appear on led_out at the following edge. This is the same cycle period_start is high, viewed at the next edge.
- On-time per period per enabled, non-blanked channel = duty_sh * PRESCALE clk cycles, contiguous, starting 1 clk after period_start rises.
- After reset release, shadows stay 0 (all LEDs off) until the first boundary, PRESCALE*2^PWM_BITS clks later.
- Reset asserted mid-period: led_out drops to 0 immediately (asynchronous). Counting restarts from 0 on release.
- No other state exists; no CPU-visible registers.

Test Plan:
All scenarios use PRESCALE=2, PWM_BITS=4, BLINK_PERIODS=2, so one period = 32 clks.
- Reset then release with led_in=0xFF, duty=8, blink_mask=0 -> led_out=0x00 for the first 32 clks after release. From the 2nd period on, led_out=0xFF for 16 clks then 0x00 for 16 clks. period_start pulses every 32 clks.
- duty=0, led_in=0xFF -> led_out stays 0x00. duty=15 -> led_out=0xFF for 30 of every 32 clks.
- Steady led_in=0x0F, duty=15; switch to 0xF0 at clk 10 of a period -> led_out keeps pattern 0x0F to period end. Pattern 0xF0 appears 1 clk after the next period_start.
- led_in=0x03, blink_mask=0x01, duty=15 -> bit1 pulses every period. bit0 pulses for 2 periods, is off for 2 periods, repeating. blink_phase toggles every 64 clks.
- Assert reset_n low at clk 5 of a period while led_out=0xFF -> led_out=0x00 and blink_phase=0 without waiting for a clk edge. After release, the first period_start occurs exactly 32 clks later.
- duty changed 4->12 in the same cycle as a boundary edge -> the new period uses 12, giving 24 on-clks.
